image_scaler_engine: RTL and testbench

Parametrised successor of the team's fixed 2x scaling datapath. It streams a source image out of a read-latency-configurable frame buffer and writes a scaled image into a destination buffer. It supports four algorithms, a runtime-selectable scale factor of 2 or 4, and a run-time source size. It sits between the source image RAM and the VGA frame buffer, under control of the coprocessor instruction decoder.

---
 rtl/image_scaler_engine.sv | 201 ++++++++++++++++++++
 tb/tb_image_scaler_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_scaler_engine.sv
// Streams a source image from a read-latency-configurable buffer into a scaled destination buffer.
// Supports NN/PR zoom-in and DC/BA zoom-out by K=2 or K=4. Has no backpressure: one read or write strobe at a time.
module image_scaler_engine #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 19,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [1:0]        ALGORITHM,
    input  logic              SCALE_SEL,
    input  logic [10:0]       SRC_WIDTH,
    input  logic [9:0]        SRC_HEIGHT,
    input  logic [DATA_W-1:0] PIXEL_IN,
    output logic [ADDR_W-1:0] R_ADDR,
    output logic              rd_en,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [DATA_W-1:0] PIXEL_OUT,
    output logic              wren_out,
    output logic              busy,
    output logic              done
);
    localparam int ACC_W = DATA_W + 4;
    localparam logic [1:0] ALG_NN = 2'd0, ALG_PR = 2'd1, ALG_DC = 2'd2, ALG_BA = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_NEXT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        alg_q, alg_d;
    logic              scale_q, scale_d;
    logic [10:0]       srcw_q, srcw_d;
    logic [9:0]        srch_q, srch_d;
    logic [12:0]       ux_q, ux_d;
    logic [11:0]       uy_q, uy_d;
    logic [1:0]        bi_q, bi_d, bj_q, bj_d;
    logic [2:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
    logic [DATA_W-1:0] pix_out_q, pix_out_d;
    logic              rd_en_q, rd_en_d, wren_q, wren_d, busy_q, busy_d, done_q, done_d;

    logic [1:0]  sh, kmax;
    logic [12:0] dw, uw;
    logic [11:0] dh, uh;
    logic        blk_last;
    logic [31:0] sx, sy, dxw, dyw;

    always_comb begin
        state_d = state_q;  alg_d = alg_q;  scale_d = scale_q;
        srcw_d = srcw_q;    srch_d = srch_q;
        ux_d = ux_q;  uy_d = uy_q;  bi_d = bi_q;  bj_d = bj_q;
        wcnt_d = wcnt_q;  pix_d = pix_q;  acc_d = acc_q;
        rd_en_d = 1'b0;  wren_d = 1'b0;  done_d = 1'b0;
        r_addr_d = '0;  w_addr_d = '0;  pix_out_d = '0;
        sx = '0;  sy = '0;  dxw = '0;  dyw = '0;

        if (state_q == S_IDLE && start) begin
            alg_d = ALGORITHM;  scale_d = SCALE_SEL;
            srcw_d = SRC_WIDTH; srch_d = SRC_HEIGHT;
        end

        // Geometry is derived from the job configuration (fresh inputs on the accepting cycle)
        sh       = scale_d ? 2'd2 : 2'd1;
        kmax     = scale_d ? 2'd3 : 2'd1;
        dw       = alg_d[1] ? ({2'b00, srcw_d} >> sh) : ({2'b00, srcw_d} << sh);
        dh       = alg_d[1] ? ({2'b00, srch_d} >> sh) : ({2'b00, srch_d} << sh);
        uw       = (alg_d == ALG_PR) ? {2'b00, srcw_d} : dw;
        uh       = (alg_d == ALG_PR) ? {2'b00, srch_d} : dh;
        blk_last = (bi_q == kmax) && (bj_q == kmax);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dw == 13'd0 || dh == 12'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                        rd_en_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                wcnt_d  = 3'd0;
            end
            S_WAIT: begin
                if (wcnt_q == 3'(RD_LATENCY - 1)) begin
                    pix_d = PIXEL_IN;
                    if (alg_q == ALG_BA) acc_d = acc_q + ACC_W'(PIXEL_IN);
                    if (alg_q == ALG_BA && !blk_last) begin
                        if (bi_q == kmax) begin
                            bi_d = 2'd0;
                            bj_d = bj_q + 2'd1;
                        end else begin
                            bi_d = bi_q + 2'd1;
                        end
                        state_d = S_READ;
                        rd_en_d = 1'b1;
                    end else begin
                        bi_d    = 2'd0;
                        bj_d    = 2'd0;
                        state_d = S_WRITE;
                        wren_d  = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            S_WRITE: begin
                // Replication burst walks the KxK destination block, columns innermost
                if (alg_q == ALG_PR && !blk_last) begin
                    if (bi_q == kmax) begin
                        bi_d = 2'd0;
                        bj_d = bj_q + 2'd1;
                    end else begin
                        bi_d = bi_q + 2'd1;
                    end
                    wren_d = 1'b1;
                end else begin
                    bi_d    = 2'd0;
                    bj_d    = 2'd0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                acc_d = '0;
                if (ux_q == uw - 13'd1) begin
                    ux_d = 13'd0;
                    if (uy_q == uh - 12'd1) begin
                        uy_d    = 12'd0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        uy_d    = uy_q + 12'd1;
                        state_d = S_READ;
                        rd_en_d = 1'b1;
                    end
                end else begin
                    ux_d    = ux_q + 13'd1;
                    state_d = S_READ;
                    rd_en_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Addresses are computed from the next counter values so the strobes stay registered
        case (alg_d)
            ALG_NN: begin sx = 32'(ux_d) >> sh; sy = 32'(uy_d) >> sh; end
            ALG_PR: begin sx = 32'(ux_d);       sy = 32'(uy_d);       end
            ALG_DC: begin sx = 32'(ux_d) << sh; sy = 32'(uy_d) << sh; end
            default: begin
                sx = (32'(ux_d) << sh) + 32'(bi_d);
                sy = (32'(uy_d) << sh) + 32'(bj_d);
            end
        endcase
        if (alg_d == ALG_PR) begin
            dxw = (32'(ux_d) << sh) + 32'(bi_d);
            dyw = (32'(uy_d) << sh) + 32'(bj_d);
        end else begin
            dxw = 32'(ux_d);
            dyw = 32'(uy_d);
        end
        if (rd_en_d) r_addr_d = ADDR_W'(sy * 32'(srcw_d) + sx);
        if (wren_d) begin
            w_addr_d  = ADDR_W'(dyw * 32'(dw) + dxw);
            pix_out_d = (alg_d == ALG_BA) ? DATA_W'(acc_d >> {sh, 1'b0}) : pix_d;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;  alg_q <= '0;  scale_q <= 1'b0;
            srcw_q <= '0;  srch_q <= '0;
            ux_q <= '0;  uy_q <= '0;  bi_q <= '0;  bj_q <= '0;
            wcnt_q <= '0;  pix_q <= '0;  acc_q <= '0;
            r_addr_q <= '0;  w_addr_q <= '0;  pix_out_q <= '0;
            rd_en_q <= 1'b0;  wren_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
        end else begin
            state_q <= state_d;  alg_q <= alg_d;  scale_q <= scale_d;
            srcw_q <= srcw_d;  srch_q <= srch_d;
            ux_q <= ux_d;  uy_q <= uy_d;  bi_q <= bi_d;  bj_q <= bj_d;
            wcnt_q <= wcnt_d;  pix_q <= pix_d;  acc_q <= acc_d;
            r_addr_q <= r_addr_d;  w_addr_q <= w_addr_d;  pix_out_q <= pix_out_d;
            rd_en_q <= rd_en_d;  wren_q <= wren_d;  busy_q <= busy_d;  done_q <= done_d;
        end
    end

    assign R_ADDR    = r_addr_q;
    assign rd_en     = rd_en_q;
    assign W_ADDR    = w_addr_q;
    assign PIXEL_OUT = pix_out_q;
    assign wren_out  = wren_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_image_scaler_engine.sv
// Scoreboard bench for image_scaler_engine: expected writes are queued per job, a monitor pops on wren_out.
module tb_image_scaler_engine;
    localparam int L = 2;

    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  ALGORITHM = 2'd0;
    logic        SCALE_SEL = 1'b0;
    logic [10:0] SRC_WIDTH = '0;
    logic [9:0]  SRC_HEIGHT = '0;
    logic [7:0]  PIXEL_IN;
    logic [18:0] R_ADDR, W_ADDR;
    logic [7:0]  PIXEL_OUT;
    logic        rd_en, wren_out, busy, done;

    logic [7:0]  mem  [0:63];
    logic [7:0]  dmem [0:255];
    logic [7:0]  pipe [0:L-1];
    wr_t         exp_q[$];
    int          checks = 0, errors = 0, n_reads = 0, n_writes = 0;
    logic [18:0] last_waddr = '0;

    image_scaler_engine #(.DATA_W(8), .ADDR_W(19), .RD_LATENCY(L)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .ALGORITHM(ALGORITHM),
        .SCALE_SEL(SCALE_SEL), .SRC_WIDTH(SRC_WIDTH), .SRC_HEIGHT(SRC_HEIGHT),
        .PIXEL_IN(PIXEL_IN), .R_ADDR(R_ADDR), .rd_en(rd_en), .W_ADDR(W_ADDR),
        .PIXEL_OUT(PIXEL_OUT), .wren_out(wren_out), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Source RAM: data for a read strobed in cycle c is presented in cycle c+L
    always @(posedge CLK) begin
        pipe[0] <= rd_en ? mem[R_ADDR[5:0]] : 8'd0;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign PIXEL_IN = pipe[L-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int a, input int d);
        wr_t e;
        e.a = 19'(a);
        e.d = 8'(d);
        exp_q.push_back(e);
    endtask

    task automatic build_exp(input logic [1:0] alg, input logic sc, input int w, input int h);
        int s, k, dw, dh, sum;
        s  = sc ? 2 : 1;
        k  = 1 << s;
        dw = alg[1] ? (w >> s) : (w << s);
        dh = alg[1] ? (h >> s) : (h << s);
        case (alg)
            2'd0: for (int y = 0; y < dh; y++) for (int x = 0; x < dw; x++)
                      push(y*dw + x, mem[(y/k)*w + x/k]);
            2'd1: for (int y = 0; y < h; y++) for (int x = 0; x < w; x++)
                      for (int j = 0; j < k; j++) for (int i = 0; i < k; i++)
                          push((y*k + j)*dw + x*k + i, mem[y*w + x]);
            2'd2: for (int y = 0; y < dh; y++) for (int x = 0; x < dw; x++)
                      push(y*dw + x, mem[(y*k)*w + x*k]);
            default: for (int y = 0; y < dh; y++) for (int x = 0; x < dw; x++) begin
                      sum = 0;
                      for (int j = 0; j < k; j++) for (int i = 0; i < k; i++)
                          sum += int'(mem[(y*k + j)*w + x*k + i]);
                      push(y*dw + x, sum / (k*k));
                  end
        endcase
    endtask

    task automatic run_job(input string nm, input logic [1:0] alg, input logic sc, input int w,
                           input int h, input int exp_cyc, input int exp_rd, input int exp_wr);
        int cnt, r0, w0;
        @(negedge CLK);
        build_exp(alg, sc, w, h);
        r0 = n_reads;
        w0 = n_writes;
        ALGORITHM = alg; SCALE_SEL = sc; SRC_WIDTH = 11'(w); SRC_HEIGHT = 10'(h);
        start = 1'b1;
        @(posedge CLK);
        #1;
        // Scramble the configuration inputs: the job must use the latched copy
        start = 1'b0;
        ALGORITHM = ~alg; SCALE_SEL = ~sc; SRC_WIDTH = 11'(w + 3); SRC_HEIGHT = 10'(h + 1);
        for (cnt = 1; cnt <= 5000; cnt++) begin
            @(negedge CLK);
            if (cnt == 1) begin
                check({nm, "_busy_first"}, busy, 1);
                check({nm, "_rd_en_first"}, rd_en, (exp_rd > 0) ? 1 : 0);
            end
            if (done) break;
        end
        check({nm, "_done_cycle"}, cnt, exp_cyc);
        check({nm, "_reads"}, n_reads - r0, exp_rd);
        check({nm, "_writes"}, n_writes - w0, exp_wr);
        check({nm, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        fork
            forever begin
                wr_t e;
                @(negedge CLK);
                if (!RESET) begin
                    if (rd_en) n_reads++;
                    check("rd_wr_overlap", {31'd0, rd_en & wren_out}, 0);
                    if (wren_out) begin
                        n_writes++;
                        dmem[W_ADDR[7:0]] = PIXEL_OUT;
                        last_waddr = W_ADDR;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: addr %0d data %0d, required none", W_ADDR, PIXEL_OUT);
                        end else begin
                            e = exp_q.pop_front();
                            check("w_addr", W_ADDR, e.a);
                            check("pixel_out", PIXEL_OUT, e.d);
                        end
                    end else begin
                        check("idle_w_addr", W_ADDR, 0);
                        check("idle_pixel_out", PIXEL_OUT, 0);
                    end
                end
            end
            begin
                int w0, k;
                #2;
                check("rst_r_addr", R_ADDR, 0);
                check("rst_rd_en", rd_en, 0);
                check("rst_w_addr", W_ADDR, 0);
                check("rst_pixel_out", PIXEL_OUT, 0);
                check("rst_wren", wren_out, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                @(negedge CLK);
                @(negedge CLK);
                RESET = 1'b0;

                for (int i = 0; i < 64; i++) mem[i] = 8'(i);
                for (int i = 0; i < 256; i++) dmem[i] = 8'hEE;
                run_job("nn", 2'd0, 1'b0, 4, 4, 64*(L+3)+1, 64, 64);
                check("nn_w9", dmem[9], 0);
                check("nn_w2", dmem[2], 1);
                check("nn_w16", dmem[16], 4);
                check("nn_w63", dmem[63], 15);

                run_job("dc", 2'd2, 1'b0, 5, 3, 2*(L+3)+1, 2, 2);
                check("dc_w1", dmem[1], 2);

                mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
                run_job("pr", 2'd1, 1'b1, 2, 2, 4*(L+2+16)+1, 4, 64);
                for (int j = 0; j < 4; j++) begin
                    for (int i = 0; i < 4; i++) begin
                        k = 8*j + i;
                        check("pr_blk0", dmem[k], 10);
                    end
                end
                check("pr_w4", dmem[4], 20);
                check("pr_w32", dmem[32], 30);
                check("pr_last_addr", last_waddr, 63);
                check("pr_w63", dmem[63], 40);

                mem[0] = 8'd255; mem[1] = 8'd255; mem[2] = 8'd255; mem[3] = 8'd254;
                run_job("ba2", 2'd3, 1'b0, 2, 2, 4*(L+1)+2+1, 4, 1);
                check("ba2_w0", dmem[0], 254);

                for (int i = 0; i < 16; i++) mem[i] = 8'd255;
                dmem[0] = 8'h00;
                run_job("ba4", 2'd3, 1'b1, 4, 4, 16*(L+1)+2+1, 16, 1);
                check("ba4_w0", dmem[0], 255);

                run_job("degen", 2'd3, 1'b1, 3, 8, 1, 0, 0);

                // Abort in the middle of the first replication burst
                mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
                @(negedge CLK);
                build_exp(2'd1, 1'b1, 2, 2);
                w0 = n_writes;
                ALGORITHM = 2'd1; SCALE_SEL = 1'b1; SRC_WIDTH = 11'd2; SRC_HEIGHT = 10'd2;
                start = 1'b1;
                @(posedge CLK);
                #1 start = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge CLK);
                    if (n_writes - w0 >= 5) break;
                end
                check("abort_reached_burst", (n_writes - w0 >= 5) ? 1 : 0, 1);
                #2 RESET = 1'b1;
                #1;
                check("abort_wren", wren_out, 0);
                check("abort_w_addr", W_ADDR, 0);
                check("abort_pixel_out", PIXEL_OUT, 0);
                check("abort_rd_en", rd_en, 0);
                check("abort_busy", busy, 0);
                exp_q.delete();
                @(negedge CLK);
                @(negedge CLK);
                RESET = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge CLK);
                    check("post_abort_quiet", {29'd0, rd_en, wren_out, done}, 0);
                end

                for (int i = 0; i < 64; i++) mem[i] = 8'(i);
                run_job("nn2", 2'd0, 1'b0, 4, 4, 64*(L+3)+1, 64, 64);
                check("nn2_w63", dmem[63], 15);
                check("nn2_w9", dmem[9], 0);

                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        join
    end
endmodule
